// File: rtl/lap_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lap_sweep_ctrl
// Description : Frame-synchronous ping-pong sweep of the delay-line tap select.
//               Optional end-of-sweep dwell is built when LAP_SWEEP_HOLD_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_sweep_ctrl #(
    parameter int MAX_DELAY_LAPS = 640,
    parameter int LAP_WIDTH      = 10,
    parameter int HOLD_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  en,
    input  logic [LAP_WIDTH-1:0]  cfg_lap_min,
    input  logic [LAP_WIDTH-1:0]  cfg_lap_max,
    input  logic [5:0]            cfg_step,
    input  logic [HOLD_WIDTH-1:0] cfg_hold,
    output logic [LAP_WIDTH-1:0]  delaylap,
    output logic                  lap_update,
    output logic [15:0]           frame_cnt,
    output logic [2:0]            sweep_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    localparam logic [LAP_WIDTH:0] c_max_lap = (LAP_WIDTH+1)'(MAX_DELAY_LAPS);

    state_t               state_q;
    logic                 vsync_q;
    logic                 vsync_dly_q;
    logic [LAP_WIDTH-1:0] delaylap_q;
    logic                 lap_update_q;
    logic [15:0]          frame_cnt_q;

    logic                 w_tick;
    logic                 w_hold_nz;
    logic                 w_step_zero;
    logic [LAP_WIDTH:0]   w_min_ext;
    logic [LAP_WIDTH:0]   w_max_ext;
    logic [LAP_WIDTH:0]   w_step;
    logic [LAP_WIDTH:0]   w_lo;
    logic [LAP_WIDTH:0]   w_hi;
    logic [LAP_WIDTH:0]   w_up_sum;
    logic                 w_up_sat;
    logic                 w_dn_sat;
    logic [LAP_WIDTH-1:0] w_dn_val;

    // Edge detect runs on the registered vsync so every tick acts one clock
    // after vsync is first sampled, with no input-to-output path.
    assign w_tick      = vsync_q & ~vsync_dly_q;
    assign w_step_zero = (cfg_step == 6'd0);

`ifdef LAP_SWEEP_HOLD_EN
    logic [HOLD_WIDTH-1:0] hold_cnt_q;
    assign w_hold_nz = (cfg_hold != '0);
`else
    logic w_unused_hold;
    assign w_unused_hold = ^cfg_hold;
    assign w_hold_nz     = 1'b0;
`endif

    always_comb begin
        w_min_ext = {1'b0, cfg_lap_min};
        w_max_ext = {1'b0, cfg_lap_max};
        w_step    = {{(LAP_WIDTH-5){1'b0}}, cfg_step};
        w_lo      = (w_min_ext > c_max_lap) ? c_max_lap : w_min_ext;
        w_hi      = (w_max_ext > c_max_lap) ? c_max_lap : w_max_ext;
        if (w_lo > w_hi) begin
            w_hi = w_lo;
        end
        w_up_sum  = {1'b0, delaylap_q} + w_step;
        w_up_sat  = (w_up_sum >= w_hi);
        // Compare against lo+step instead of subtracting, so no wrap below 0.
        w_dn_sat  = ({1'b0, delaylap_q} <= (w_lo + w_step));
        w_dn_val  = delaylap_q - {{(LAP_WIDTH-6){1'b0}}, cfg_step};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            vsync_dly_q  <= 1'b0;
            delaylap_q   <= '0;
            lap_update_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
`ifdef LAP_SWEEP_HOLD_EN
            hold_cnt_q   <= '0;
`endif
        end else begin
            vsync_q      <= i_vsync;
            vsync_dly_q  <= vsync_q;
            lap_update_q <= w_tick;
            if (w_tick) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (!en) begin
                    state_q    <= S_IDLE;
                    delaylap_q <= w_lo[LAP_WIDTH-1:0];
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            state_q    <= S_UP;
                            delaylap_q <= w_lo[LAP_WIDTH-1:0];
                        end
                        S_UP: begin
                            if (!w_step_zero) begin
                                if (w_up_sat) begin
                                    delaylap_q <= w_hi[LAP_WIDTH-1:0];
                                    if (w_hold_nz) begin
                                        state_q <= S_HOLD_HI;
`ifdef LAP_SWEEP_HOLD_EN
                                        hold_cnt_q <= cfg_hold;
`endif
                                    end else begin
                                        state_q <= S_DOWN;
                                    end
                                end else begin
                                    delaylap_q <= w_up_sum[LAP_WIDTH-1:0];
                                end
                            end
                        end
                        S_DOWN: begin
                            if (!w_step_zero) begin
                                if (w_dn_sat) begin
                                    delaylap_q <= w_lo[LAP_WIDTH-1:0];
                                    if (w_hold_nz) begin
                                        state_q <= S_HOLD_LO;
`ifdef LAP_SWEEP_HOLD_EN
                                        hold_cnt_q <= cfg_hold;
`endif
                                    end else begin
                                        state_q <= S_UP;
                                    end
                                end else begin
                                    delaylap_q <= w_dn_val;
                                end
                            end
                        end
`ifdef LAP_SWEEP_HOLD_EN
                        S_HOLD_HI: begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                            if (hold_cnt_q <= 1) begin
                                state_q <= S_DOWN;
                            end
                        end
                        S_HOLD_LO: begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                            if (hold_cnt_q <= 1) begin
                                state_q <= S_UP;
                            end
                        end
`endif
                        default: begin
                            state_q    <= S_IDLE;
                            delaylap_q <= w_lo[LAP_WIDTH-1:0];
                        end
                    endcase
                end
            end
        end
    end

    assign delaylap    = delaylap_q;
    assign lap_update  = lap_update_q;
    assign frame_cnt   = frame_cnt_q;
    assign sweep_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lap_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lap_sweep_ctrl
// Description : Self-checking bench for lap_sweep_ctrl against a frame-level
//               behavioural model. Honors LAP_SWEEP_HOLD_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_sweep_ctrl;

    localparam int MAXL = 640;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_vsync = 1'b0;
    logic        en = 1'b0;
    logic [9:0]  cfg_lap_min = '0;
    logic [9:0]  cfg_lap_max = '0;
    logic [5:0]  cfg_step = '0;
    logic [7:0]  cfg_hold = '0;
    logic [9:0]  delaylap;
    logic        lap_update;
    logic [15:0] frame_cnt;
    logic [2:0]  sweep_state;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;
    bit hold_en;

    // reference model: position, phase (0 idle,1 up,2 dwell hi,3 down,4 dwell lo)
    int m_lap, m_state, m_dwell, m_frames;

    lap_sweep_ctrl #(.MAX_DELAY_LAPS(640), .LAP_WIDTH(10), .HOLD_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync), .en(en),
        .cfg_lap_min(cfg_lap_min), .cfg_lap_max(cfg_lap_max),
        .cfg_step(cfg_step), .cfg_hold(cfg_hold),
        .delaylap(delaylap), .lap_update(lap_update),
        .frame_cnt(frame_cnt), .sweep_state(sweep_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (lap_update === 1'b1) upd_cnt++;

    task automatic model_tick();
        int lo, hi, st, hd;
        lo = (int'(cfg_lap_min) > MAXL) ? MAXL : int'(cfg_lap_min);
        hi = (int'(cfg_lap_max) > MAXL) ? MAXL : int'(cfg_lap_max);
        if (lo > hi) hi = lo;
        st = int'(cfg_step);
        hd = hold_en ? int'(cfg_hold) : 0;
        m_frames = (m_frames + 1) % 65536;
        if (!en) begin
            m_state = 0; m_lap = lo;
        end else if (m_state == 0) begin
            m_state = 1; m_lap = lo;
        end else if (m_state == 2 || m_state == 4) begin
            if (m_dwell == 1) m_state = (m_state == 2) ? 3 : 1;
            m_dwell = m_dwell - 1;
        end else if (st != 0) begin
            if (m_state == 1) begin
                if (m_lap + st >= hi) begin
                    m_lap = hi;
                    m_state = (hd == 0) ? 3 : 2;
                    m_dwell = hd;
                end else m_lap = m_lap + st;
            end else begin
                if (m_lap - st <= lo) begin
                    m_lap = lo;
                    m_state = (hd == 0) ? 1 : 4;
                    m_dwell = hd;
                end else m_lap = m_lap - st;
            end
        end
    endtask

    task automatic set_cfg(input bit e, input int mn, input int mx, input int st, input int hd);
        en = e;
        cfg_lap_min = 10'(mn);
        cfg_lap_max = 10'(mx);
        cfg_step = 6'(st);
        cfg_hold = 8'(hd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_vsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_lap = 0; m_state = 0; m_dwell = 0; m_frames = 0;
        upd_cnt = 0;
    endtask

    // one-cycle vsync; returns at the first negedge after outputs update (+gap)
    task automatic vs_pulse(input int gap);
        @(negedge clk) i_vsync = 1'b1;
        @(negedge clk) i_vsync = 1'b0;
        model_tick();
        @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        n_tests++;
        if (delaylap !== 10'(m_lap) || sweep_state !== 3'(m_state) || frame_cnt !== 16'(m_frames)) begin
            n_fail++;
            $display("FAIL %s: got lap=%0d st=%0d fc=%0d, want lap=%0d st=%0d fc=%0d",
                     tag, delaylap, sweep_state, frame_cnt, m_lap, m_state, m_frames);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (delaylap !== 10'd0 || lap_update !== 1'b0 || frame_cnt !== 16'd0 || sweep_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got lap=%0d upd=%0b fc=%0d st=%0d, want all 0",
                     delaylap, lap_update, frame_cnt, sweep_state);
        end
        set_cfg(1, 100, 300, 20, 1);
        repeat (4) vs_pulse(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (delaylap !== 10'd0 || frame_cnt !== 16'd0 || sweep_state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got lap=%0d fc=%0d st=%0d, want 0 0 0",
                     delaylap, frame_cnt, sweep_state);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        m_lap = 0; m_state = 0; m_dwell = 0; m_frames = 0;
        vs_pulse(1);
        check_model("first_tick_after_reset");
    endtask

    task automatic test_basic_sweep();
        int exp_seq [12];
        if (hold_en) exp_seq = '{0, 4, 8, 10, 10, 10, 6, 2, 0, 0, 0, 4};
        else         exp_seq = '{0, 4, 8, 10, 6, 2, 0, 4, 8, 10, 6, 2};
        do_reset();
        set_cfg(1, 0, 10, 4, 2);
        for (int i = 0; i < 12; i++) begin
            vs_pulse(1);
            n_tests++;
            if (delaylap !== 10'(exp_seq[i])) begin
                n_fail++;
                $display("FAIL basic_sweep[%0d]: got %0d, want %0d", i, delaylap, exp_seq[i]);
            end
            check_model("basic_sweep_model");
        end
        n_tests++;
        if (upd_cnt != 12 || frame_cnt !== 16'd12) begin
            n_fail++;
            $display("FAIL basic_counts: got upd=%0d fc=%0d, want 12 12", upd_cnt, frame_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_cfg(1, 600, 1000, 63, 3);
        for (int i = 0; i < 8; i++) begin
            vs_pulse(0);
            n_tests++;
            if (delaylap > 10'd640 || (i == 0 && delaylap !== 10'd600) || (i == 1 && delaylap !== 10'd640)) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %0d, want <=640 (600,640 first)", i, delaylap);
            end
            check_model("saturation_model");
        end
    endtask

    task automatic test_inverted();
        do_reset();
        set_cfg(1, 50, 20, 5, 1);
        for (int i = 0; i < 20; i++) begin
            vs_pulse(0);
            n_tests++;
            if (delaylap !== 10'd50) begin
                n_fail++;
                $display("FAIL inverted[%0d]: got %0d, want 50", i, delaylap);
            end
        end
        check_model("inverted_model");
    endtask

    task automatic test_midframe();
        logic [9:0] lap0;
        logic [2:0] st0;
        do_reset();
        set_cfg(1, 100, 400, 30, 0);
        repeat (3) vs_pulse(1);
        lap0 = delaylap;
        st0 = sweep_state;
        en = 1'b0;
        cfg_lap_min = 10'd7;
        repeat (3) @(negedge clk);
        n_tests++;
        if (delaylap !== lap0 || sweep_state !== st0) begin
            n_fail++;
            $display("FAIL midframe_hold: got lap=%0d st=%0d, want lap=%0d st=%0d", delaylap, sweep_state, lap0, st0);
        end
        @(negedge clk) i_vsync = 1'b1;
        @(negedge clk) i_vsync = 1'b0;
        model_tick();
        n_tests++;
        if (delaylap !== lap0 || lap_update !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_latency: got lap=%0d upd=%0b before N+1, want lap=%0d upd=0", delaylap, lap_update, lap0);
        end
        @(negedge clk);
        n_tests++;
        if (delaylap !== 10'd7 || sweep_state !== 3'd0 || lap_update !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_apply: got lap=%0d st=%0d upd=%0b, want 7 0 1", delaylap, sweep_state, lap_update);
        end
        @(negedge clk);
        n_tests++;
        if (lap_update !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_update_width: got %0b, want 0", lap_update);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_cfg(1, 0, 500, 9, 1);
        @(negedge clk) i_vsync = 1'b1;
        repeat (10) @(negedge clk);
        i_vsync = 1'b0;
        model_tick();
        @(negedge clk);
        n_tests++;
        if (frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL long_vsync: got fc=%0d, want 1", frame_cnt);
        end
        @(negedge clk) i_vsync = 1'b1;
        @(negedge clk) i_vsync = 1'b0;
        @(negedge clk) i_vsync = 1'b1;
        model_tick();
        @(negedge clk) i_vsync = 1'b0;
        model_tick();
        repeat (2) @(negedge clk);
        check_model("back_to_back");
    endtask

    task automatic test_random();
        do_reset();
        set_cfg(1, 0, 200, 13, 2);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_cfg($urandom_range(0, 15) != 0, $urandom_range(0, 700), $urandom_range(0, 1023),
                        ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63), $urandom_range(0, 4));
            end
            vs_pulse($urandom_range(0, 3));
            check_model("random");
        end
    endtask

    initial begin
`ifdef LAP_SWEEP_HOLD_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        test_reset();
        test_basic_sweep();
        test_saturation();
        test_inverted();
        test_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
